// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the multiplexed-digit scan controller.
// Holds the FSM encoding, default timing constants and the counter sizing helper.
package digit_scan_pkg;

  localparam int unsigned NUM_DIGITS    = 4;
  localparam int unsigned SEL_W         = 2;
  localparam int unsigned DWELL_DEFAULT = 1000;
  localparam int unsigned BLANK_DEFAULT = 16;

  typedef logic [SEL_W-1:0]      sel_t;
  typedef logic [NUM_DIGITS-1:0] mask_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  // Counter must reach max(dwell, blank)-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned dwell, input int unsigned blank);
    int unsigned max_cnt;
    max_cnt = (dwell > blank) ? dwell : blank;
    return (max_cnt > 1) ? $clog2(max_cnt) : 1;
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Control/status bundle between the scan controller and its parent.
// The parent (master) drives enable and mask; the controller (slave) drives the demux.
interface digit_scan_ctrl_if;
  import digit_scan_pkg::*;

  logic  en;
  mask_t digit_mask;
  sel_t  sel;
  logic  out_en;
  logic  frame_tick;

  modport master (
    output en,
    output digit_mask,
    input  sel,
    input  out_en,
    input  frame_tick
  );

  modport slave (
    input  en,
    input  digit_mask,
    output sel,
    output out_en,
    output frame_tick
  );

endinterface

// File: rtl/scan_next_sel.sv
// Cyclic search for the next set mask bit strictly after cur_i (3 wraps to 0).
// wrap_o flags that the found index is <= cur_i; found_o is low for an empty mask.
module scan_next_sel
  import digit_scan_pkg::*;
(
  input  sel_t  cur_i,
  input  mask_t mask_i,
  output sel_t  next_o,
  output logic  wrap_o,
  output logic  found_o
);

  localparam int unsigned SUM_W = SEL_W + 1;

  logic [SUM_W-1:0] sum;

  // The carry out of cur_i + k is exactly the wrap condition for k in 1..NUM_DIGITS.
  always_comb begin
    next_o  = cur_i;
    wrap_o  = 1'b0;
    found_o = 1'b0;
    sum     = '0;
    for (int unsigned k = 1; k <= NUM_DIGITS; k++) begin
      sum = {1'b0, cur_i} + SUM_W'(k);
      if (!found_o && mask_i[sum[SEL_W-1:0]]) begin
        found_o = 1'b1;
        next_o  = sum[SEL_W-1:0];
        wrap_o  = sum[SEL_W];
      end
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scan: shows each enabled digit for DWELL cycles with
// BLANK dark cycles between digits, and pulses frame_tick when the scan wraps.
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int unsigned DWELL = DWELL_DEFAULT,
  parameter int unsigned BLANK = BLANK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  digit_scan_ctrl_if.slave scan_if
);

  localparam int unsigned CNT_W = cnt_width(DWELL, BLANK);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sel_t             sel_q, sel_d;
  logic             out_en_q, out_en_d;
  logic             tick_q, tick_d;

  sel_t  search_cur;
  sel_t  next_sel;
  logic  next_wrap;
  logic  next_found;
  logic  dwell_done;
  logic  blank_done;

  // From IDLE, searching after index 3 yields the lowest set index.
  assign search_cur = (state_q == ST_IDLE) ? SEL_W'(NUM_DIGITS - 1) : sel_q;
  assign dwell_done = (cnt_q == CNT_W'(DWELL - 1));
  assign blank_done = (cnt_q == CNT_W'(BLANK - 1));

  scan_next_sel u_next (
    .cur_i   (search_cur),
    .mask_i  (scan_if.digit_mask),
    .next_o  (next_sel),
    .wrap_o  (next_wrap),
    .found_o (next_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      out_en_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      out_en_q <= out_en_d;
      tick_q   <= tick_d;
    end
  end

  // Mask is only consulted at the IDLE->SHOW and BLANK->SHOW decisions; sel moves only
  // on entry to SHOW, while out_en is still low, so an active output never glitches.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    out_en_d = out_en_q;
    tick_d   = 1'b0;

    if (!scan_if.en) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      sel_d    = '0;
      out_en_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d    = '0;
          sel_d    = '0;
          out_en_d = 1'b0;
          if (next_found) begin
            state_d  = ST_SHOW;
            sel_d    = next_sel;
            out_en_d = 1'b1;
          end
        end

        ST_SHOW: begin
          if (dwell_done) begin
            state_d  = ST_BLANK;
            cnt_d    = '0;
            out_en_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_BLANK: begin
          if (blank_done) begin
            cnt_d = '0;
            if (next_found) begin
              state_d  = ST_SHOW;
              sel_d    = next_sel;
              out_en_d = 1'b1;
              tick_d   = next_wrap;
            end else begin
              state_d  = ST_IDLE;
              sel_d    = '0;
              out_en_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          sel_d    = '0;
          out_en_d = 1'b0;
        end
      endcase
    end
  end

  assign scan_if.sel        = sel_q;
  assign scan_if.out_en     = out_en_q;
  assign scan_if.frame_tick = tick_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl (DWELL=4, BLANK=2): slot-based reference model,
// per-cycle compare, directed scenarios with literal expectations, then random traffic.
module tb_digit_scan_ctrl;

  localparam int DW   = 4;
  localparam int BL   = 2;
  localparam int SLOT = DW + BL;

  logic clk = 1'b0;
  logic rst;

  digit_scan_ctrl_if sif ();

  digit_scan_ctrl #(.DWELL(DW), .BLANK(BL)) dut (
    .clk     (clk),
    .rst     (rst),
    .scan_if (sif)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Reference model: a digit occupies a slot of DWELL lit + BLANK dark cycles.
  int   m_run = 0;
  int   m_digit = 0;
  int   m_age = 0;
  int   m_tick = 0;
  int   m_epoch = 0;

  function automatic int lowest_set(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int next_set(input int cur, input logic [3:0] m);
    for (int j = 1; j <= 4; j++) if (m[(cur + j) % 4]) return (cur + j) % 4;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int nd;
    if (rst) begin
      m_run = 0; m_digit = 0; m_age = 0; m_tick = 0;
      m_epoch++;
    end else begin
      m_tick = 0;
      if (!sif.en) begin
        m_run = 0;
      end else if (m_run == 0) begin
        if (sif.digit_mask != 4'b0) begin
          m_run = 1; m_age = 0; m_digit = lowest_set(sif.digit_mask);
        end
      end else begin
        m_age++;
        if (m_age == SLOT) begin
          nd = next_set(m_digit, sif.digit_mask);
          if (nd < 0) m_run = 0;
          else begin
            m_tick  = (nd <= m_digit) ? 1 : 0;
            m_digit = nd;
            m_age   = 0;
          end
        end
      end
    end
  end

  function automatic logic [7:0] exp_sel();
    return (m_run != 0) ? 8'(m_digit) : 8'd0;
  endfunction
  function automatic logic [7:0] exp_oe();
    return (m_run != 0 && m_age < DW) ? 8'd1 : 8'd0;
  endfunction

  // Per-cycle compare against the model plus the no-glitch invariant.
  logic [1:0] prev_sel = 2'd0;
  logic       prev_oe = 1'b0;
  int         prev_epoch = 0;

  always @(negedge clk) begin
    check("sel", 8'(sif.sel), exp_sel());
    check("out_en", 8'(sif.out_en), exp_oe());
    check("frame_tick", 8'(sif.frame_tick), 8'(m_tick));
    if (prev_oe === 1'b1 && sif.out_en === 1'b1 && prev_epoch == m_epoch)
      check("sel_stable", 8'(sif.sel), 8'(prev_sel));
    prev_oe    = sif.out_en;
    prev_sel   = sif.sel;
    prev_epoch = m_epoch;
  end

  logic [1:0] cap_sel [64];
  logic       cap_oe  [64];
  logic       cap_tk  [64];
  int         cap_mtk [64];

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_sel[i] = sif.sel;
      cap_oe[i]  = sif.out_en;
      cap_tk[i]  = sif.frame_tick;
      cap_mtk[i] = m_tick;
    end
  endtask

  task automatic tick_stats(input int n, output int cnt, output int first);
    cnt = 0; first = -1;
    for (int i = 0; i < n; i++) if (cap_tk[i] === 1'b1) begin
      if (first < 0) first = i;
      cnt++;
    end
  endtask

  // Leaves the caller at the edge that starts the first SHOW cycle (c=0).
  task automatic restart(input logic [3:0] m);
    @(posedge clk); #1 sif.en = 1'b0;
    @(posedge clk); #1 sif.en = 1'b1; sif.digit_mask = m;
    @(posedge clk);
  endtask

  initial begin
    int tc, tf, r;
    rst = 1'b1;
    sif.en = 1'b0;
    sif.digit_mask = 4'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel", 8'(sif.sel), 8'd0);
    check("rst_out_en", 8'(sif.out_en), 8'd0);
    check("rst_tick", 8'(sif.frame_tick), 8'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Four digits: 0,1,2,3,0 with 24-cycle frame.
    restart(4'b1111);
    capture(50);
    check("m1111_sel_c0", 8'(cap_sel[0]), 8'd0);
    check("m1111_sel_c6", 8'(cap_sel[6]), 8'd1);
    check("m1111_sel_c12", 8'(cap_sel[12]), 8'd2);
    check("m1111_sel_c18", 8'(cap_sel[18]), 8'd3);
    check("m1111_sel_c24", 8'(cap_sel[24]), 8'd0);
    check("m1111_oe_c3", 8'(cap_oe[3]), 8'd1);
    check("m1111_oe_c4", 8'(cap_oe[4]), 8'd0);
    check("m1111_oe_c5", 8'(cap_oe[5]), 8'd0);
    check("m1111_oe_c6", 8'(cap_oe[6]), 8'd1);
    tick_stats(50, tc, tf);
    check("m1111_tick_cnt", 8'(tc), 8'd2);
    check("m1111_tick_first", 8'(tf), 8'd24);
    check("model_tick24", 8'(cap_mtk[24]), 8'd1);

    // Alternating digits 1,3.
    restart(4'b1010);
    capture(50);
    check("m1010_sel_c0", 8'(cap_sel[0]), 8'd1);
    check("m1010_sel_c6", 8'(cap_sel[6]), 8'd3);
    check("m1010_sel_c12", 8'(cap_sel[12]), 8'd1);
    tick_stats(50, tc, tf);
    check("m1010_tick_cnt", 8'(tc), 8'd4);
    check("m1010_tick_first", 8'(tf), 8'd12);

    // Single digit ticks every slot from the second SHOW on.
    restart(4'b0100);
    capture(50);
    check("m0100_sel_c0", 8'(cap_sel[0]), 8'd2);
    check("m0100_sel_c40", 8'(cap_sel[40]), 8'd2);
    check("m0100_oe_c3", 8'(cap_oe[3]), 8'd1);
    check("m0100_oe_c4", 8'(cap_oe[4]), 8'd0);
    tick_stats(50, tc, tf);
    check("m0100_tick_cnt", 8'(tc), 8'd8);
    check("m0100_tick_first", 8'(tf), 8'd6);
    check("model_tick0", 8'(cap_mtk[0]), 8'd0);

    // Enable dropped in 2nd SHOW cycle of sel=1.
    restart(4'b1111);
    repeat (7) @(posedge clk);
    #1 sif.en = 1'b0;
    @(negedge clk);
    check("en_drop_pre_sel", 8'(sif.sel), 8'd1);
    check("en_drop_pre_oe", 8'(sif.out_en), 8'd1);
    @(posedge clk); #1;
    check("en_drop_sel", 8'(sif.sel), 8'd0);
    check("en_drop_oe", 8'(sif.out_en), 8'd0);
    sif.en = 1'b1;
    @(posedge clk);
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      check("reen_oe", 8'(sif.out_en), 8'd1);
      check("reen_sel", 8'(sif.sel), 8'd0);
    end
    @(negedge clk);
    check("reen_oe_end", 8'(sif.out_en), 8'd0);

    // Asynchronous reset in the BLANK after sel=1.
    restart(4'b1111);
    repeat (10) @(posedge clk);
    #2 check("arst_pre_sel", 8'(sif.sel), 8'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_sel", 8'(sif.sel), 8'd0);
    check("arst_oe", 8'(sif.out_en), 8'd0);
    check("arst_tick", 8'(sif.frame_tick), 8'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("arst_restart_sel", 8'(sif.sel), 8'd0);
    check("arst_restart_oe", 8'(sif.out_en), 8'd1);

    // Mask cleared during SHOW of sel=2: slot completes, then idle.
    restart(4'b1111);
    repeat (13) @(posedge clk);
    #1 sif.digit_mask = 4'b0000;
    for (int i = 13; i < 30; i++) begin
      @(negedge clk);
      check("mclr_oe", 8'(sif.out_en), (i <= 15) ? 8'd1 : 8'd0);
      check("mclr_sel", 8'(sif.sel), (i <= 17) ? 8'd2 : 8'd0);
    end

    // Random traffic against the model.
    sif.digit_mask = 4'($urandom);
    sif.en = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      r = int'($urandom_range(0, 99));
      if (r < 2) sif.en = 1'b0;
      else if (r < 6) sif.en = 1'b1;
      if ($urandom_range(0, 39) == 0) sif.digit_mask = 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
